// File: rtl/i2c_bit_ctrl_pkg.sv
// Shared definitions for the I2C bit engine and the byte controller above it:
// command codes, phase encoding, line-drive record and line-drive lookup.
package i2c_pkg;

  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_READ  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    PH_C = 3'd3,
    PH_D = 3'd4
  } phase_e;

  // Open-drain drive enables: 1 pulls the line low, 0 releases it.
  typedef struct packed {
    logic scl_oe;
    logic sda_oe;
  } lines_t;

  function automatic logic cmd_known(input logic [2:0] cmd);
    return (cmd == CMD_START) || (cmd == CMD_STOP) ||
           (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

  // Line drive for a command in a given phase; IDLE and "hold" keep cur.
  function automatic lines_t phase_lines(input logic [2:0] cmd, input phase_e ph,
                                         input logic din, input lines_t cur);
    lines_t l;
    l = cur;
    case (cmd)
      CMD_START: begin
        case (ph)
          PH_A, PH_B: begin l.sda_oe = 1'b0; l.scl_oe = 1'b0; end
          PH_C:       begin l.sda_oe = 1'b1; l.scl_oe = 1'b0; end
          PH_D:       begin l.sda_oe = 1'b1; l.scl_oe = 1'b1; end
          default:    l = cur;
        endcase
      end
      CMD_STOP: begin
        case (ph)
          PH_A:    begin l.sda_oe = 1'b1; l.scl_oe = 1'b1; end
          PH_B:    begin l.sda_oe = 1'b1; l.scl_oe = 1'b0; end
          PH_C:    begin l.sda_oe = 1'b0; l.scl_oe = 1'b0; end
          default: l = cur;
        endcase
      end
      CMD_WRITE, CMD_READ: begin
        l.sda_oe = (cmd == CMD_WRITE) ? ~din : 1'b0;
        case (ph)
          PH_A, PH_D: l.scl_oe = 1'b1;
          PH_B, PH_C: l.scl_oe = 1'b0;
          default:    l = cur;
        endcase
      end
      default: l = cur;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/i2c_bit_ctrl_if.sv
// Command handshake and open-drain pad signals of the I2C bit engine.
interface i2c_bit_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic       cmd_din;
  logic       done;
  logic       dout;
  logic       arb_lost;
  logic       bus_busy;
  logic       scl_i;
  logic       sda_i;
  logic       scl_oe;
  logic       sda_oe;

  // Engine side.
  modport slave (
    input  cmd_valid, cmd, cmd_din, scl_i, sda_i,
    output cmd_ready, done, dout, arb_lost, bus_busy, scl_oe, sda_oe
  );

  // Byte controller side.
  modport master (
    output cmd_valid, cmd, cmd_din,
    input  cmd_ready, done, dout, arb_lost, bus_busy
  );
endinterface

// File: rtl/i2c_bit_ctrl_sync2.sv
// Two-flop synchronizer for an I2C pad input; resets to 1 (idle bus level).
module i2c_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;

  // Shift the pad value through two flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff_q <= 2'b11;
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/i2c_bit_ctrl.sv
// I2C bit engine: executes one START/STOP/WRITE/READ command as four
// prescaled quarter-period phases, with clock stretching and arbitration check.
module i2c_bit_ctrl #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic           clk,
  input  logic           rst,
  i2c_bit_ctrl_if.slave  bus
);
  import i2c_pkg::*;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 32'd1);

  phase_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  cmd_q, cmd_d;
  logic        din_q, din_d;
  lines_t      lines_q, lines_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        arb_q, arb_d;
  logic        busy_q, busy_d;
  logic        sample_q, sample_d;
  logic        dout_q, dout_d;

  logic scl_s, sda_s;
  logic accept_s, stretch_s, arb_s;

  i2c_sync2 u_scl_sync (.clk(clk), .rst(rst), .d_i(bus.scl_i), .q_o(scl_s));
  i2c_sync2 u_sda_sync (.clk(clk), .rst(rst), .d_i(bus.sda_i), .q_o(sda_s));

  assign accept_s  = bus.cmd_valid & ready_q;
  // A released SCL that still reads low is being held by a slave.
  assign stretch_s = ((state_q == PH_B) || (state_q == PH_C)) && !lines_q.scl_oe && !scl_s;
  // We released SDA to send a 1 but somebody else is pulling it low.
  assign arb_s     = (state_q == PH_C) && (cmd_q == CMD_WRITE) && din_q && !sda_s;

  // Next-state, phase counter and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    din_d    = din_q;
    done_d   = 1'b0;
    arb_d    = 1'b0;
    busy_d   = busy_q;
    sample_d = sample_q;
    dout_d   = dout_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (cmd_known(bus.cmd)) begin
            state_d = PH_A;
            cnt_d   = DIV_M1;
            cmd_d   = bus.cmd;
            din_d   = bus.cmd_din;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      PH_A, PH_B, PH_C, PH_D: begin
        if (arb_s) begin
          state_d = IDLE;
          arb_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (stretch_s) begin
          cnt_d = cnt_q;
        end else if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          cnt_d = DIV_M1;
          case (state_q)
            PH_A: state_d = PH_B;
            PH_B: state_d = PH_C;
            PH_C: begin
              state_d  = PH_D;
              sample_d = sda_s;
            end
            PH_D: begin
              state_d = IDLE;
              done_d  = 1'b1;
              if (cmd_q == CMD_START) begin
                busy_d = 1'b1;
              end else if (cmd_q == CMD_STOP) begin
                busy_d = 1'b0;
              end else begin
                busy_d = busy_q;
              end
              if (cmd_q == CMD_READ) begin
                dout_d = sample_q;
              end else begin
                dout_d = dout_q;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    // Lines are driven from the next phase so they switch with the boundary.
    if (arb_s) begin
      lines_d = '0;
    end else begin
      lines_d = phase_lines(cmd_d, state_d, din_d, lines_q);
    end
    ready_d = (state_d == IDLE);
  end

  // Phase state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter, latched command and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= 16'd0;
      cmd_q    <= 3'd0;
      din_q    <= 1'b0;
      lines_q  <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      arb_q    <= 1'b0;
      busy_q   <= 1'b0;
      sample_q <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      din_q    <= din_d;
      lines_q  <= lines_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      arb_q    <= arb_d;
      busy_q   <= busy_d;
      sample_q <= sample_d;
      dout_q   <= dout_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.arb_lost  = arb_q;
  assign bus.bus_busy  = busy_q;
  assign bus.dout      = dout_q;
  assign bus.scl_oe    = lines_q.scl_oe;
  assign bus.sda_oe    = lines_q.sda_oe;
endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Scoreboard bench for i2c_bit_ctrl with CLK_DIV=4 and pull-ups on both lines.
module tb_i2c_bit_ctrl;
  import i2c_pkg::*;

  logic clk;
  logic rst_n;
  logic slave_scl_low;
  logic slave_sda_low;
  logic scl_pad;
  logic sda_pad;
  int   cyc;
  int   errors;
  int   checks;

  // line logger state
  bit   win;
  int   scl_rises;
  int   sda_glitch;
  int   sda_fall_hi_cyc;
  int   sda_rise_hi_cyc;
  int   scl_fall_cyc;

  typedef struct {
    bit is_arb;
    bit chk_dout;
    bit dout;
    bit busy;
    bit chk_oe;
    bit scl_oe;
    bit sda_oe;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];

  i2c_bit_ctrl_if bus();

  i2c_bit_ctrl #(.CLK_DIV(4)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  assign scl_pad   = ~bus.scl_oe & ~slave_scl_low;
  assign sda_pad   = ~bus.sda_oe & ~slave_sda_low;
  assign bus.scl_i = scl_pad;
  assign bus.sda_i = sda_pad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int lat, input bit busy);
    exp_t e;
    e.is_arb = 1'b0; e.chk_dout = 1'b0; e.dout = 1'b0; e.busy = busy;
    e.chk_oe = 1'b0; e.scl_oe = 1'b0; e.sda_oe = 1'b0; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk_rd(input int lat, input bit busy, input bit d);
    exp_t e;
    e = mk(lat, busy);
    e.chk_dout = 1'b1; e.dout = d;
    return e;
  endfunction

  function automatic exp_t mk_oe(input int lat, input bit busy, input bit arb,
                                 input bit scl_oe, input bit sda_oe);
    exp_t e;
    e = mk(lat, busy);
    e.is_arb = arb; e.chk_oe = 1'b1; e.scl_oe = scl_oe; e.sda_oe = sda_oe;
    return e;
  endfunction

  // Present a command, wait for it to be accepted, queue its expected result.
  task automatic issue(input logic [2:0] c, input logic d, input exp_t e, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.cmd_din   = d;
    while (!bus.cmd_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus.cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: cmd_ready=0 expected 1 for cmd %0d", c);
      bus.cmd_valid = 1'b0;
      acc = 0;
    end else begin
      acc   = cyc;
      e.acc = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
    end
  endtask

  // Wait until every queued response has been seen.
  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL response_timeout: pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: pop and compare on every done or arb_lost pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.done || bus.arb_lost)) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: done=%0b arb_lost=%0b expected neither", bus.done, bus.arb_lost);
        end else begin
          e = sb.pop_front();
          check("arb_lost", int'(bus.arb_lost), int'(e.is_arb));
          check("done", int'(bus.done), int'(!e.is_arb));
          check("latency", cyc - e.acc, e.lat);
          check("bus_busy", int'(bus.bus_busy), int'(e.busy));
          if (e.chk_dout) check("dout", int'(bus.dout), int'(e.dout));
          if (e.chk_oe) begin
            check("scl_oe", int'(bus.scl_oe), int'(e.scl_oe));
            check("sda_oe", int'(bus.sda_oe), int'(e.sda_oe));
          end
        end
      end
    end
  end

  // Line logger: SCL/SDA edges with the cycle they were seen in.
  initial begin
    logic scl_prev, sda_prev;
    scl_prev = 1'b1; sda_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (scl_pad && !scl_prev && win) scl_rises++;
      if (!scl_pad && scl_prev) scl_fall_cyc = cyc;
      if (scl_pad && scl_prev && (sda_pad != sda_prev)) begin
        if (win) sda_glitch++;
        if (sda_pad) sda_rise_hi_cyc = cyc;
        else         sda_fall_hi_cyc = cyc;
      end
      scl_prev = scl_pad;
      sda_prev = sda_pad;
    end
  end

  initial begin
    int a0, a1, a2, a3, a4;
    errors = 0; checks = 0; win = 1'b0;
    scl_rises = 0; sda_glitch = 0;
    sda_fall_hi_cyc = 0; sda_rise_hi_cyc = 0; scl_fall_cyc = 0;
    rst_n = 1'b0;
    slave_scl_low = 1'b0; slave_sda_low = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd = 3'd0; bus.cmd_din = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_done", int'(bus.done), 0);
    check("rst_arb_lost", int'(bus.arb_lost), 0);
    check("rst_dout", int'(bus.dout), 0);
    check("rst_bus_busy", int'(bus.bus_busy), 0);
    check("rst_scl_oe", int'(bus.scl_oe), 0);
    check("rst_sda_oe", int'(bus.sda_oe), 0);
    rst_n = 1'b1;

    // START from an idle bus
    issue(CMD_START, 1'b0, mk(17, 1'b1), a0);
    wait_idle();
    check("start_sda_fall_cycle", sda_fall_hi_cyc - a0, 9);
    check("start_scl_fall_cycle", scl_fall_cyc - a0, 13);

    // WRITE 1,0,1 back-to-back, then STOP
    win = 1'b1; scl_rises = 0; sda_glitch = 0;
    issue(CMD_WRITE, 1'b1, mk(19, 1'b1), a1);
    issue(CMD_WRITE, 1'b0, mk(19, 1'b1), a2);
    issue(CMD_WRITE, 1'b1, mk(19, 1'b1), a3);
    issue(CMD_STOP,  1'b0, mk(19, 1'b0), a4);
    win = 1'b0;
    check("b2b_gap_1", a2 - a1, 19);
    check("b2b_gap_2", a3 - a2, 19);
    check("b2b_gap_3", a4 - a3, 19);
    check("write_scl_pulses", scl_rises, 3);
    check("write_sda_change_scl_high", sda_glitch, 0);
    wait_idle();
    check("stop_sda_rise_cycle", sda_rise_hi_cyc - a4, 11);

    // READs: released, slave drives 0, released
    issue(CMD_START, 1'b0, mk(17, 1'b1), a0);
    issue(CMD_READ, 1'b0, mk_rd(19, 1'b1, 1'b1), a1);
    wait_idle();
    slave_sda_low = 1'b1;
    issue(CMD_READ, 1'b0, mk_rd(19, 1'b1, 1'b0), a1);
    wait_idle();
    slave_sda_low = 1'b0;
    issue(CMD_READ, 1'b0, mk_rd(19, 1'b1, 1'b1), a1);
    issue(CMD_STOP, 1'b0, mk(19, 1'b0), a1);
    wait_idle();
    check("dout_held_after_stop", int'(bus.dout), 1);

    // Clock stretch: slave holds SCL low for the first 20 cycles of PH_B
    issue(CMD_START, 1'b0, mk(17, 1'b1), a0);
    wait_idle();
    issue(CMD_WRITE, 1'b0, mk(39, 1'b1), a1);
    while (cyc < a1 + 4) @(negedge clk);
    slave_scl_low = 1'b1;
    while (cyc < a1 + 25) @(negedge clk);
    slave_scl_low = 1'b0;
    wait_idle();
    issue(CMD_STOP, 1'b0, mk(19, 1'b0), a1);
    wait_idle();

    // Arbitration loss: another master pulls SDA low in PH_C of WRITE 1
    issue(CMD_START, 1'b0, mk(17, 1'b1), a0);
    wait_idle();
    issue(CMD_WRITE, 1'b1, mk_oe(14, 1'b0, 1'b1, 1'b0, 1'b0), a1);
    while (cyc < a1 + 11) @(negedge clk);
    slave_sda_low = 1'b1;
    wait_idle();
    slave_sda_low = 1'b0;
    repeat (20) @(negedge clk);

    // Reset in PH_C of WRITE 0
    issue(CMD_START, 1'b0, mk(17, 1'b1), a0);
    wait_idle();
    issue(CMD_WRITE, 1'b0, mk(19, 1'b1), a1);
    while (cyc < a1 + 12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_sda_oe", int'(bus.sda_oe), 0);
    check("midrst_scl_oe", int'(bus.scl_oe), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_cmd_ready", int'(bus.cmd_ready), 1);
    check("midrst_bus_busy", int'(bus.bus_busy), 0);
    check("midrst_dout", int'(bus.dout), 0);
    repeat (40) @(negedge clk);

    // Invalid command codes: one-cycle done, lines untouched
    issue(3'd0, 1'b0, mk_oe(1, 1'b0, 1'b0, 1'b0, 1'b0), a0);
    issue(CMD_START, 1'b0, mk(17, 1'b1), a0);
    issue(3'd6, 1'b1, mk_oe(1, 1'b1, 1'b0, 1'b1, 1'b1), a1);
    issue(3'd7, 1'b0, mk_oe(1, 1'b1, 1'b0, 1'b1, 1'b1), a2);
    issue(CMD_STOP, 1'b0, mk(19, 1'b0), a3);
    wait_idle();
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
